// File: rtl/mcu_el2_lsu_region_guard.sv
// mcu_el2_lsu_region_guard
//
// Runtime-programmable data-access checker for the EL2 LSU. NUM_WIN windows,
// each made of base/mask/ctrl registers written through a small config port.
// A D-stage request is checked against the windows, and the result is
// registered into M. The first effective fault is captured in a record with
// an overflow flag and a saturating fault counter.
//
// Optional feature: define MCU_LSU_REGION_GUARD_LOCK_EN to enable the
// per-window LOCK bit (ctrl[3]). When the bit is set, that window's registers
// are frozen until reset.
//
// Ports
//   clk, rst_l                   clock, async active-low reset
//   cfg_we/idx/sel/wdata         window register write (sel 0 base, 1 mask, 2 ctrl)
//   cfg_rdata                    combinational read of cfg_idx/cfg_sel
//   req_*_d                      D-stage request (valid, start/end address, store, dma)
//   flush_m                      kills the M-stage response
//   resp_valid_m/fault_m/mscause_m   M-stage check result
//   flt_valid/addr/cause/store/overflow/count   fault record
//   flt_clr                      clears the fault record and counter
module mcu_el2_lsu_region_guard #(
  parameter int unsigned NUM_WIN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned IdxW   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             cfg_we,
  input  logic [IdxW-1:0]  cfg_idx,
  input  logic [1:0]       cfg_sel,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             req_valid_d,
  input  logic [31:0]      req_start_addr_d,
  input  logic [31:0]      req_end_addr_d,
  input  logic             req_store_d,
  input  logic             req_dma_d,
  input  logic             flush_m,
  output logic             resp_valid_m,
  output logic             resp_fault_m,
  output logic [3:0]       resp_mscause_m,
  output logic             flt_valid,
  output logic [31:0]      flt_addr,
  output logic [3:0]       flt_cause,
  output logic             flt_store,
  output logic             flt_overflow,
  input  logic             flt_clr,
  output logic [CNT_W-1:0] flt_count
);

  localparam logic [3:0] CauseMisalign = 4'd2;
  localparam logic [3:0] CauseNoHit    = 4'd3;
  localparam logic [3:0] CausePerm     = 4'd7;

  // Window registers
  logic [31:0] base_q [NUM_WIN];
  logic [31:0] base_d [NUM_WIN];
  logic [31:0] mask_q [NUM_WIN];
  logic [31:0] mask_d [NUM_WIN];
  logic [3:0]  ctrl_q [NUM_WIN];
  logic [3:0]  ctrl_d [NUM_WIN];

  logic [NUM_WIN-1:0] win_sel;
  logic [NUM_WIN-1:0] win_lock;
  logic [3:0]         ctrl_wval;

`ifdef MCU_LSU_REGION_GUARD_LOCK_EN
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:4];
  assign ctrl_wval    = cfg_wdata[3:0];
  always_comb begin
    win_lock = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      win_lock[i] = ctrl_q[i][3];
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:3];
  // LOCK is not stored, so ctrl[3] always reads 0 and no window freezes.
  assign ctrl_wval    = {1'b0, cfg_wdata[2:0]};
  assign win_lock     = '0;
`endif

  // Indices at or above NUM_WIN select nothing: writes drop and reads return 0.
  always_comb begin
    win_sel = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      win_sel[i] = (cfg_idx == IdxW'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      base_d[i] = base_q[i];
      mask_d[i] = mask_q[i];
      ctrl_d[i] = ctrl_q[i];
      if (cfg_we && win_sel[i] && !win_lock[i]) begin
        case (cfg_sel)
          2'd0:    base_d[i] = cfg_wdata;
          2'd1:    mask_d[i] = cfg_wdata;
          2'd2:    ctrl_d[i] = ctrl_wval;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        base_q[i] <= base_d[i];
        mask_q[i] <= mask_d[i];
        ctrl_q[i] <= ctrl_d[i];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (win_sel[i]) begin
        case (cfg_sel)
          2'd0:    cfg_rdata = base_q[i];
          2'd1:    cfg_rdata = mask_q[i];
          2'd2:    cfg_rdata = {28'd0, ctrl_q[i]};
          default: cfg_rdata = '0;
        endcase
      end
    end
  end

  // D-stage check
  logic [NUM_WIN-1:0] win_en;
  logic [NUM_WIN-1:0] win_grant;
  logic [NUM_WIN-1:0] start_hit;
  logic [NUM_WIN-1:0] end_hit;
  logic               chk_fault;
  logic [3:0]         chk_cause;

  always_comb begin
    win_en    = '0;
    win_grant = '0;
    start_hit = '0;
    end_hit   = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      win_en[i]    = ctrl_q[i][0];
      win_grant[i] = req_store_d ? ctrl_q[i][2] : ctrl_q[i][1];
      start_hit[i] = win_en[i] && ((req_start_addr_d | mask_q[i]) == (base_q[i] | mask_q[i]));
      end_hit[i]   = win_en[i] && ((req_end_addr_d | mask_q[i]) == (base_q[i] | mask_q[i]));
    end
  end

  always_comb begin
    chk_fault = 1'b0;
    chk_cause = 4'd0;
    if (req_dma_d) begin
      chk_fault = 1'b0;
    end else if (req_start_addr_d[31:28] != req_end_addr_d[31:28]) begin
      chk_fault = 1'b1;
      chk_cause = CauseMisalign;
    end else if (win_en == '0) begin
      chk_fault = 1'b0;
    end else if ((start_hit == '0) || (end_hit == '0)) begin
      chk_fault = 1'b1;
      chk_cause = CauseNoHit;
    end else if (((start_hit & win_grant) == '0) || ((end_hit & win_grant) == '0)) begin
      chk_fault = 1'b1;
      chk_cause = CausePerm;
    end
  end

  // D -> M pipeline register
  logic        valid_q, fault_q, store_q;
  logic [3:0]  cause_q;
  logic [31:0] addr_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 4'd0;
      addr_q  <= '0;
      store_q <= 1'b0;
    end else begin
      valid_q <= req_valid_d;
      fault_q <= req_valid_d & chk_fault;
      cause_q <= (req_valid_d & chk_fault) ? chk_cause : 4'd0;
      addr_q  <= req_start_addr_d;
      store_q <= req_store_d;
    end
  end

  assign resp_valid_m   = valid_q & ~flush_m;
  assign resp_fault_m   = resp_valid_m & fault_q;
  assign resp_mscause_m = resp_fault_m ? cause_q : 4'd0;

  // Fault record
  logic             flt_valid_q, flt_valid_d;
  logic [31:0]      flt_addr_q, flt_addr_d;
  logic [3:0]       flt_cause_q, flt_cause_d;
  logic             flt_store_q, flt_store_d;
  logic             flt_ovf_q, flt_ovf_d;
  logic [CNT_W-1:0] flt_cnt_q, flt_cnt_d;

  always_comb begin
    flt_valid_d = flt_valid_q;
    flt_addr_d  = flt_addr_q;
    flt_cause_d = flt_cause_q;
    flt_store_d = flt_store_q;
    flt_ovf_d   = flt_ovf_q;
    flt_cnt_d   = flt_cnt_q;
    // Clear is applied first so a fault in the same cycle is captured fresh.
    if (flt_clr) begin
      flt_valid_d = 1'b0;
      flt_addr_d  = '0;
      flt_cause_d = 4'd0;
      flt_store_d = 1'b0;
      flt_ovf_d   = 1'b0;
      flt_cnt_d   = '0;
    end
    if (resp_fault_m) begin
      if (!flt_valid_d) begin
        flt_valid_d = 1'b1;
        flt_addr_d  = addr_q;
        flt_cause_d = cause_q;
        flt_store_d = store_q;
      end else begin
        flt_ovf_d = 1'b1;
      end
      if (flt_cnt_d != '1) begin
        flt_cnt_d = flt_cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      flt_valid_q <= 1'b0;
      flt_addr_q  <= '0;
      flt_cause_q <= 4'd0;
      flt_store_q <= 1'b0;
      flt_ovf_q   <= 1'b0;
      flt_cnt_q   <= '0;
    end else begin
      flt_valid_q <= flt_valid_d;
      flt_addr_q  <= flt_addr_d;
      flt_cause_q <= flt_cause_d;
      flt_store_q <= flt_store_d;
      flt_ovf_q   <= flt_ovf_d;
      flt_cnt_q   <= flt_cnt_d;
    end
  end

  assign flt_valid    = flt_valid_q;
  assign flt_addr     = flt_addr_q;
  assign flt_cause    = flt_cause_q;
  assign flt_store    = flt_store_q;
  assign flt_overflow = flt_ovf_q;
  assign flt_count    = flt_cnt_q;

endmodule

// File: tb/tb_mcu_el2_lsu_region_guard.sv
// Bench for mcu_el2_lsu_region_guard: directed vector table, hand sequences for
// the fault record, flush, reset and lock behaviour, then randomized traffic
// against a behavioural model. A second instance with CNT_W = 2 shares all
// inputs to observe counter saturation.
module tb_mcu_el2_lsu_region_guard;

`ifdef MCU_LSU_REGION_GUARD_LOCK_EN
  localparam bit LockOn = 1'b1;
`else
  localparam bit LockOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        req_valid_d, req_store_d, req_dma_d, flush_m, flt_clr;
  logic [31:0] req_start_addr_d, req_end_addr_d;

  logic [31:0] cfg_rdata, flt_addr;
  logic        resp_valid_m, resp_fault_m, flt_valid, flt_store, flt_overflow;
  logic [3:0]  resp_mscause_m, flt_cause;
  logic [7:0]  flt_count;

  logic [31:0] d2_cfg_rdata, d2_flt_addr;
  logic        d2_resp_valid_m, d2_resp_fault_m, d2_flt_valid, d2_flt_store, d2_flt_overflow;
  logic [3:0]  d2_resp_mscause_m, d2_flt_cause;
  logic [1:0]  d2_flt_count;

  always #5 clk = ~clk;

  mcu_el2_lsu_region_guard #(.NUM_WIN(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_l(rst_l), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .req_valid_d(req_valid_d),
    .req_start_addr_d(req_start_addr_d), .req_end_addr_d(req_end_addr_d),
    .req_store_d(req_store_d), .req_dma_d(req_dma_d), .flush_m(flush_m),
    .resp_valid_m(resp_valid_m), .resp_fault_m(resp_fault_m), .resp_mscause_m(resp_mscause_m),
    .flt_valid(flt_valid), .flt_addr(flt_addr), .flt_cause(flt_cause), .flt_store(flt_store),
    .flt_overflow(flt_overflow), .flt_clr(flt_clr), .flt_count(flt_count)
  );

  mcu_el2_lsu_region_guard #(.NUM_WIN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_l(rst_l), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_rdata(d2_cfg_rdata), .req_valid_d(req_valid_d),
    .req_start_addr_d(req_start_addr_d), .req_end_addr_d(req_end_addr_d),
    .req_store_d(req_store_d), .req_dma_d(req_dma_d), .flush_m(flush_m),
    .resp_valid_m(d2_resp_valid_m), .resp_fault_m(d2_resp_fault_m),
    .resp_mscause_m(d2_resp_mscause_m), .flt_valid(d2_flt_valid), .flt_addr(d2_flt_addr),
    .flt_cause(d2_flt_cause), .flt_store(d2_flt_store), .flt_overflow(d2_flt_overflow),
    .flt_clr(flt_clr), .flt_count(d2_flt_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] w_base [8];
  logic [31:0] w_mask [8];
  logic [3:0]  w_ctrl [8];
  logic        m_valid, m_fault, m_store;
  logic [3:0]  m_cause;
  logic [31:0] m_addr;
  logic        r_valid, r_store, r_ovf;
  logic [31:0] r_addr;
  logic [3:0]  r_cause;
  int          r_cnt, r_cnt2;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      w_base[i] = '0; w_mask[i] = '0; w_ctrl[i] = '0;
    end
    m_valid = 0; m_fault = 0; m_store = 0; m_cause = 0; m_addr = 0;
    r_valid = 0; r_store = 0; r_ovf = 0; r_addr = 0; r_cause = 0; r_cnt = 0; r_cnt2 = 0;
  endtask

  function automatic bit hits(input int i, input logic [31:0] a);
    return w_ctrl[i][0] && ((a | w_mask[i]) == (w_base[i] | w_mask[i]));
  endfunction

  // Returns {fault, cause}
  function automatic logic [4:0] ref_check(input logic [31:0] sa, input logic [31:0] ea,
                                           input logic st, input logic dma);
    bit any_en = 0, sh = 0, eh = 0, sp = 0, ep = 0, ok;
    if (dma) return 5'd0;
    if (sa[31:28] != ea[31:28]) return {1'b1, 4'd2};
    for (int i = 0; i < 8; i++) begin
      ok = st ? w_ctrl[i][2] : w_ctrl[i][1];
      if (w_ctrl[i][0]) any_en = 1;
      if (hits(i, sa)) begin sh = 1; if (ok) sp = 1; end
      if (hits(i, ea)) begin eh = 1; if (ok) ep = 1; end
    end
    if (!any_en) return 5'd0;
    if (!sh || !eh) return {1'b1, 4'd3};
    if (!sp || !ep) return {1'b1, 4'd7};
    return 5'd0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [2:0] idx, input logic [1:0] sel);
    case (sel)
      2'd0:    return w_base[idx];
      2'd1:    return w_mask[idx];
      2'd2:    return {28'd0, w_ctrl[idx]};
      default: return 32'd0;
    endcase
  endfunction

  // State change at the coming clock edge, using the inputs currently driven.
  task automatic model_edge();
    logic eff;
    logic [4:0] rc;
    eff = m_valid & ~flush_m & m_fault;
    if (flt_clr) begin
      r_valid = 0; r_store = 0; r_ovf = 0; r_addr = 0; r_cause = 0; r_cnt = 0; r_cnt2 = 0;
    end
    if (eff) begin
      if (!r_valid) begin
        r_valid = 1; r_addr = m_addr; r_cause = m_cause; r_store = m_store;
      end else begin
        r_ovf = 1;
      end
      if (r_cnt < 255) r_cnt++;
      if (r_cnt2 < 3) r_cnt2++;
    end
    rc = ref_check(req_start_addr_d, req_end_addr_d, req_store_d, req_dma_d);
    m_valid = req_valid_d;
    m_fault = req_valid_d & rc[4];
    m_cause = m_fault ? rc[3:0] : 4'd0;
    m_addr  = req_start_addr_d;
    m_store = req_store_d;
    if (cfg_we && cfg_sel != 2'd3 && !(LockOn && w_ctrl[cfg_idx][3])) begin
      case (cfg_sel)
        2'd0:    w_base[cfg_idx] = cfg_wdata;
        2'd1:    w_mask[cfg_idx] = cfg_wdata;
        default: w_ctrl[cfg_idx] = LockOn ? cfg_wdata[3:0] : {1'b0, cfg_wdata[2:0]};
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic        s_valid, s_fault;
  logic [3:0]  s_cause;
  logic [31:0] s_faddr;
  logic        s_fvalid, s_fovf;
  logic [7:0]  s_fcnt;
  logic [1:0]  s_fcnt2;

  task automatic set_idle();
    cfg_we = 0; cfg_idx = 0; cfg_sel = 0; cfg_wdata = 0;
    req_valid_d = 0; req_start_addr_d = 0; req_end_addr_d = 0;
    req_store_d = 0; req_dma_d = 0; flush_m = 0; flt_clr = 0;
  endtask

  task automatic set_req(input logic [31:0] sa, input logic [31:0] ea, input logic st,
                         input logic dma);
    req_valid_d = 1; req_start_addr_d = sa; req_end_addr_d = ea;
    req_store_d = st; req_dma_d = dma;
  endtask

  task automatic set_cfg(input logic [2:0] idx, input logic [1:0] sel, input logic [31:0] wd);
    cfg_we = 1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = wd;
  endtask

  // Called just after a falling edge with inputs driven; ends at the next falling edge.
  task automatic run_cycle();
    logic       ev, ef;
    logic [3:0] ec;
    #1;
    ev = m_valid & ~flush_m;
    ef = ev & m_fault;
    ec = ef ? m_cause : 4'd0;
    s_valid = resp_valid_m; s_fault = resp_fault_m; s_cause = resp_mscause_m;
    chk("resp_valid_m", 32'(resp_valid_m), 32'(ev));
    chk("resp_fault_m", 32'(resp_fault_m), 32'(ef));
    chk("resp_mscause_m", 32'(resp_mscause_m), 32'(ec));
    chk("cfg_rdata", cfg_rdata, ref_read(cfg_idx, cfg_sel));
    chk("dut2 resp", 32'({d2_resp_valid_m, d2_resp_fault_m, d2_resp_mscause_m}),
        32'({ev, ef, ec}));
    model_edge();
    @(posedge clk);
    #1;
    s_fvalid = flt_valid; s_faddr = flt_addr; s_fovf = flt_overflow;
    s_fcnt = flt_count; s_fcnt2 = d2_flt_count;
    chk("flt_valid", 32'(flt_valid), 32'(r_valid));
    chk("flt_addr", flt_addr, r_addr);
    chk("flt_cause", 32'(flt_cause), 32'(r_cause));
    chk("flt_store", 32'(flt_store), 32'(r_store));
    chk("flt_overflow", 32'(flt_overflow), 32'(r_ovf));
    chk("flt_count", 32'(flt_count), 32'(r_cnt));
    chk("dut2 flt_count", 32'(d2_flt_count), 32'(r_cnt2));
    chk("dut2 record", {d2_flt_valid, d2_flt_store, d2_flt_overflow, d2_flt_cause,
        d2_flt_addr[24:0]}, {r_valid, r_store, r_ovf, r_cause, r_addr[24:0]});
    chk("dut2 cfg_rdata", d2_cfg_rdata, cfg_rdata);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rst_l = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_l = 1;
    #1;
    chk("reset outputs", 32'({resp_valid_m, resp_fault_m, resp_mscause_m, flt_valid,
        flt_store, flt_overflow, flt_cause, flt_count}), 32'd0);
    chk("reset flt_addr", flt_addr, 32'd0);
    chk("reset cfg_rdata", cfg_rdata, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] sa;
    logic [31:0] ea;
    logic        st;
    logic        dma;
    logic        ef;
    logic [3:0]  ec;
  } vec_t;

  vec_t vecs[8];

  initial begin
    set_idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state: no window enabled, load passes
    set_req(32'h2000_0000, 32'h2000_0003, 0, 0);
    run_cycle();
    set_idle();
    run_cycle();
    chk("first load valid", 32'(s_valid), 32'd1);
    chk("first load fault", 32'({s_fault, s_cause}), 32'd0);
    chk("first load count", 32'(s_fcnt), 32'd0);

    // Window 0: 0x4000_xxxx, EN+RD
    set_cfg(0, 0, 32'h4000_0000); run_cycle();
    set_cfg(0, 1, 32'h0000_FFFF); run_cycle();
    set_cfg(0, 2, 32'h0000_0003); run_cycle();
    set_idle();

    vecs[0] = '{32'h4000_0010, 32'h4000_0013, 1, 0, 1, 4'd7};
    vecs[1] = '{32'h4000_0010, 32'h4000_0013, 0, 0, 0, 4'd0};
    vecs[2] = '{32'h5000_0000, 32'h5000_0003, 0, 0, 1, 4'd3};
    vecs[3] = '{32'h4FFF_FFFE, 32'h5000_0001, 0, 0, 1, 4'd2};
    vecs[4] = '{32'h4FFF_FFFE, 32'h5000_0001, 0, 1, 0, 4'd0};
    vecs[5] = '{32'h4001_0000, 32'h4001_0003, 0, 0, 1, 4'd3};
    vecs[6] = '{32'h4000_FFFE, 32'h4001_0001, 0, 0, 1, 4'd3};
    vecs[7] = '{32'h4000_0010, 32'h4000_0013, 1, 1, 0, 4'd0};
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_req(vecs[i].sa, vecs[i].ea, vecs[i].st, vecs[i].dma);
      run_cycle();
      set_idle();
      run_cycle();
      chk($sformatf("vec%0d valid", i), 32'(s_valid), 32'd1);
      chk($sformatf("vec%0d fault", i), 32'(s_fault), 32'(vecs[i].ef));
      chk($sformatf("vec%0d mscause", i), 32'(s_cause), 32'(vecs[i].ec));
    end

    // Fault record: first fault kept, second sets overflow
    set_idle(); flt_clr = 1; run_cycle();
    set_idle(); set_req(32'h5000_0000, 32'h5000_0003, 0, 0); run_cycle();
    set_idle(); set_req(32'h4000_0010, 32'h4000_0013, 1, 0); run_cycle();
    set_idle(); run_cycle();
    run_cycle();
    chk("rec addr", s_faddr, 32'h5000_0000);
    chk("rec overflow", 32'(s_fovf), 32'd1);
    chk("rec count", 32'(s_fcnt), 32'd2);
    // Clear together with a third fault
    set_idle(); set_req(32'h6000_0000, 32'h6000_0003, 0, 0); run_cycle();
    set_idle(); flt_clr = 1; run_cycle();
    chk("clr+fault count", 32'(s_fcnt), 32'd1);
    chk("clr+fault overflow", 32'(s_fovf), 32'd0);
    chk("clr+fault addr", s_faddr, 32'h6000_0000);
    chk("clr+fault valid", 32'(s_fvalid), 32'd1);

    // Flushed fault is dropped
    set_idle(); set_req(32'h7000_0000, 32'h7000_0003, 0, 0); run_cycle();
    set_idle(); flush_m = 1; run_cycle();
    chk("flush valid", 32'(s_valid), 32'd0);
    chk("flush rec addr", s_faddr, 32'h6000_0000);
    chk("flush rec count", 32'(s_fcnt), 32'd1);

    // Five faults: narrow counter saturates at 3
    set_idle(); flt_clr = 1; run_cycle();
    for (int i = 0; i < 5; i++) begin
      set_idle(); set_req(32'h5000_0000 + 32'(i * 4), 32'h5000_0000 + 32'(i * 4), 0, 0);
      run_cycle();
    end
    set_idle(); run_cycle();
    run_cycle();
    chk("cnt8 after 5", 32'(s_fcnt), 32'd5);
    chk("cnt2 saturated", 32'(s_fcnt2), 32'd3);

    // Asynchronous reset with a fault in flight
    set_idle(); set_req(32'h5000_0000, 32'h5000_0003, 0, 0); run_cycle();
    set_idle();
    rst_l = 0;
    #1;
    chk("midreset resp_valid", 32'(resp_valid_m), 32'd0);
    chk("midreset record", 32'({flt_valid, flt_overflow, flt_count}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1;
    @(negedge clk);

    // Lock behaviour on window 1
    set_idle(); set_cfg(1, 2, 32'h0000_0009); run_cycle();
    set_idle(); set_cfg(1, 0, 32'h1234_0000); run_cycle();
    set_idle(); cfg_idx = 1; cfg_sel = 0; #1;
    chk("lock base", cfg_rdata, LockOn ? 32'h0 : 32'h1234_0000);
    cfg_sel = 2; #1;
    chk("lock ctrl", cfg_rdata, LockOn ? 32'h9 : 32'h1);
    @(negedge clk);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int unsigned j;
      logic [31:0] sa, ea, wd;
      logic [1:0]  sel;
      set_idle();
      if ($urandom_range(0, 3) == 0) begin
        sel = 2'($urandom_range(0, 3));
        case (sel)
          2'd0: wd = {4'($urandom_range(4, 6)), 28'($urandom)};
          2'd1: wd = (32'h1 << $urandom_range(4, 27)) - 32'h1;
          2'd2: wd = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7))
                     | (($urandom_range(0, 15) == 0) ? 32'h8 : 32'h0);
          default: wd = $urandom;
        endcase
        set_cfg(3'($urandom_range(0, 7)), sel, wd);
      end else begin
        cfg_idx = 3'($urandom_range(0, 7));
        cfg_sel = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) != 0) begin
        j = $urandom_range(0, 7);
        if ($urandom_range(0, 3) != 0) sa = (w_base[j] & ~w_mask[j]) | ($urandom & w_mask[j]);
        else sa = {4'($urandom_range(4, 6)), 28'($urandom)};
        ea = ($urandom_range(0, 15) == 0) ? sa + 32'h0800_0000 : sa + 32'($urandom_range(0, 7));
        set_req(sa, ea, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      flush_m = ($urandom_range(0, 7) == 0);
      flt_clr = ($urandom_range(0, 15) == 0);
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
